usb_rx_pkt_parser: RTL and testbench

- Receive-side packet parser that sits directly upstream of the link controller.
- Accepts the byte stream produced by the NRZI-decode/bit-unstuff stage and validates the PID.
- Checks CRC5 on tokens and CRC16 on data packets, and extracts the token address and endpoint.
- Signals one completed packet per EOP on `rx_pkt_valid`, with PID, error flags and field values alongside, in the format the link state machine consumes.

---
 rtl/usb_rx_pkt_parser.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_usb_rx_pkt_parser.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_pkt_parser.sv
// usb_rx_pkt_parser
//   Receive-side USB packet parser between the NRZI-decode/bit-unstuff stage
//   and the link controller. Validates the PID, checks CRC5 on tokens and
//   CRC16 on data packets, extracts the token address/endpoint, and reports
//   one completed packet per EOP with PID, error flags and field values.
//
// Build option:
//   USB_RX_PAYLOAD_EN  when defined, payload bytes are forwarded on
//                      rx_data_out/rx_data_valid through a 2-byte delay line
//                      so the CRC bytes never appear; otherwise both are 0.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   self_addr[6:0]           device address for token address match
//   rx_byte[7:0]             received byte (LSB first on the wire)
//   rx_byte_valid            rx_byte valid this cycle
//   rx_sop                   qualifies the PID byte
//   rx_eop                   one-cycle pulse after the last byte
//   rx_abort                 line error, drops the packet in progress
//   rx_pkt_valid             one-cycle packet-complete pulse
//   rx_pid_val[3:0]          PID of the completed packet
//   crc5_err, crc16_err      CRC residual mismatch (token / data)
//   pid_err, len_err         bad/unknown PID, wrong byte count
//   addr_match               IN/OUT/SETUP token addressed to self_addr
//   rx_endp[3:0]             token endpoint
//   rx_payload_len[10:0]     data payload byte count
//   rx_data_out[7:0]         forwarded payload byte
//   rx_data_valid            payload byte strobe
module usb_rx_pkt_parser #(
   parameter int unsigned MAX_PAYLOAD = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  self_addr,
   input  logic [7:0]  rx_byte,
   input  logic        rx_byte_valid,
   input  logic        rx_sop,
   input  logic        rx_eop,
   input  logic        rx_abort,
   output logic        rx_pkt_valid,
   output logic [3:0]  rx_pid_val,
   output logic        crc5_err,
   output logic        crc16_err,
   output logic        pid_err,
   output logic        len_err,
   output logic        addr_match,
   output logic [3:0]  rx_endp,
   output logic [10:0] rx_payload_len,
   output logic [7:0]  rx_data_out,
   output logic        rx_data_valid
);
   localparam int unsigned CNT_W = 11;
   localparam logic [CNT_W-1:0] CNT_SAT   = '1;
   localparam logic [CNT_W-1:0] TOKEN_LEN = CNT_W'(2);
   localparam logic [CNT_W-1:0] CRC_BYTES = CNT_W'(2);
   localparam logic [31:0]      DATA_MAX  = 32'(MAX_PAYLOAD) + 32'd2;
   localparam logic [4:0]       CRC5_INIT  = 5'h1F;
   localparam logic [4:0]       CRC5_GOOD  = 5'h0C;
   localparam logic [15:0]      CRC16_INIT = 16'hFFFF;
   localparam logic [15:0]      CRC16_GOOD = 16'h800D;
   localparam logic [3:0]       PID_SOF    = 4'b0101;

   // The PID is decoded on the SOP byte itself, so there is no separate
   // PID-wait state and a data byte may follow the PID in the next cycle.
   typedef enum logic [2:0] {ST_IDLE, ST_TOKEN, ST_DATA, ST_HSK, ST_DROP} state_e;

   state_e           state_q, state_d;
   logic [3:0]       pid_q, pid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       crc5_q, crc5_d;
   logic [15:0]      crc16_q, crc16_d;
   logic [6:0]       addr_q, addr_d;
   logic [3:0]       endp_q, endp_d;
   logic             pkt_valid_q, pkt_valid_d;
   logic [3:0]       pid_val_q, pid_val_d;
   logic             crc5_err_q, crc5_err_d;
   logic             crc16_err_q, crc16_err_d;
   logic             pid_err_q, pid_err_d;
   logic             len_err_q, len_err_d;
   logic             addr_match_q, addr_match_d;
   logic [3:0]       endp_out_q, endp_out_d;
   logic [10:0]      payload_len_q, payload_len_d;

   // One byte of CRC5 (x^5+x^2+1), bit 0 first
   function automatic logic [4:0] crc5_byte(input logic [4:0] crc_in, input logic [7:0] b);
      logic [4:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[4] ^ b[i]) c = {c[3:0], 1'b0} ^ 5'h05;
         else             c = {c[3:0], 1'b0};
      end
      return c;
   endfunction

   // One byte of CRC16 (0x8005), bit 0 first
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
      logic [15:0] c;
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // Packet state, field capture and status generation
   always_comb begin
      state_d       = state_q;
      pid_d         = pid_q;
      cnt_d         = cnt_q;
      crc5_d        = crc5_q;
      crc16_d       = crc16_q;
      addr_d        = addr_q;
      endp_d        = endp_q;
      pkt_valid_d   = 1'b0;
      pid_val_d     = pid_val_q;
      crc5_err_d    = crc5_err_q;
      crc16_err_d   = crc16_err_q;
      pid_err_d     = pid_err_q;
      len_err_d     = len_err_q;
      addr_match_d  = addr_match_q;
      endp_out_d    = endp_out_q;
      payload_len_d = payload_len_q;

      if (rx_abort) begin
         state_d = ST_IDLE;
      end else begin
         if (rx_byte_valid && rx_sop) begin
            // A new PID always restarts parsing, discarding any packet in flight
            pid_d   = rx_byte[3:0];
            cnt_d   = '0;
            crc5_d  = CRC5_INIT;
            crc16_d = CRC16_INIT;
            addr_d  = '0;
            endp_d  = '0;
            if (rx_byte[7:4] != ~rx_byte[3:0]) begin
               state_d = ST_DROP;
            end else begin
               unique case (rx_byte[3:0])
                  4'b0001, 4'b1001, 4'b0101, 4'b1101: state_d = ST_TOKEN;
                  4'b0011, 4'b1011:                   state_d = ST_DATA;
                  4'b0010, 4'b1010, 4'b1110:          state_d = ST_HSK;
                  default:                            state_d = ST_DROP;
               endcase
            end
         end else if (rx_byte_valid && (state_q != ST_IDLE)) begin
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
            case (state_q)
               ST_TOKEN: begin
                  if (cnt_q == CNT_W'(0)) begin
                     addr_d    = rx_byte[6:0];
                     endp_d[0] = rx_byte[7];
                  end
                  if (cnt_q == CNT_W'(1)) endp_d[3:1] = rx_byte[2:0];
                  if (cnt_q < TOKEN_LEN)  crc5_d = crc5_byte(crc5_q, rx_byte);
               end
               ST_DATA: crc16_d = crc16_byte(crc16_q, rx_byte);
               default: ;
            endcase
         end

         // EOP is evaluated after any byte accepted in the same cycle
         if (rx_eop && (state_d != ST_IDLE)) begin
            pkt_valid_d   = 1'b1;
            pid_val_d     = pid_d;
            crc5_err_d    = 1'b0;
            crc16_err_d   = 1'b0;
            pid_err_d     = 1'b0;
            len_err_d     = 1'b0;
            addr_match_d  = 1'b0;
            endp_out_d    = '0;
            payload_len_d = '0;
            case (state_d)
               ST_TOKEN: begin
                  len_err_d    = (cnt_d != TOKEN_LEN);
                  crc5_err_d   = (cnt_d == TOKEN_LEN) && (crc5_d != CRC5_GOOD);
                  addr_match_d = (pid_d != PID_SOF) && (addr_d == self_addr);
                  endp_out_d   = endp_d;
               end
               ST_DATA: begin
                  len_err_d     = (cnt_d < CRC_BYTES) || (32'(cnt_d) > DATA_MAX);
                  crc16_err_d   = (crc16_d != CRC16_GOOD);
                  payload_len_d = cnt_d - CRC_BYTES;
               end
               ST_HSK:  len_err_d = (cnt_d != CNT_W'(0));
               default: pid_err_d = 1'b1;
            endcase
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pid_q         <= '0;
         cnt_q         <= '0;
         crc5_q        <= CRC5_INIT;
         crc16_q       <= CRC16_INIT;
         addr_q        <= '0;
         endp_q        <= '0;
         pkt_valid_q   <= 1'b0;
         pid_val_q     <= '0;
         crc5_err_q    <= 1'b0;
         crc16_err_q   <= 1'b0;
         pid_err_q     <= 1'b0;
         len_err_q     <= 1'b0;
         addr_match_q  <= 1'b0;
         endp_out_q    <= '0;
         payload_len_q <= '0;
      end else begin
         state_q       <= state_d;
         pid_q         <= pid_d;
         cnt_q         <= cnt_d;
         crc5_q        <= crc5_d;
         crc16_q       <= crc16_d;
         addr_q        <= addr_d;
         endp_q        <= endp_d;
         pkt_valid_q   <= pkt_valid_d;
         pid_val_q     <= pid_val_d;
         crc5_err_q    <= crc5_err_d;
         crc16_err_q   <= crc16_err_d;
         pid_err_q     <= pid_err_d;
         len_err_q     <= len_err_d;
         addr_match_q  <= addr_match_d;
         endp_out_q    <= endp_out_d;
         payload_len_q <= payload_len_d;
      end
   end

   assign rx_pkt_valid   = pkt_valid_q;
   assign rx_pid_val     = pid_val_q;
   assign crc5_err       = crc5_err_q;
   assign crc16_err      = crc16_err_q;
   assign pid_err        = pid_err_q;
   assign len_err        = len_err_q;
   assign addr_match     = addr_match_q;
   assign rx_endp        = endp_out_q;
   assign rx_payload_len = payload_len_q;

`ifdef USB_RX_PAYLOAD_EN
   logic [7:0] dl0_q, dl0_d, dl1_q, dl1_d;
   logic [1:0] held_q, held_d;
   logic [7:0] data_out_q, data_out_d;
   logic       data_valid_q, data_valid_d;

   // Two-byte delay line: a byte leaves only once two newer bytes arrived,
   // so the trailing CRC pair is never forwarded.
   always_comb begin
      dl0_d        = dl0_q;
      dl1_d        = dl1_q;
      held_d       = held_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      if (rx_abort || (rx_byte_valid && rx_sop)) begin
         held_d = '0;
      end else if (rx_byte_valid && (state_q == ST_DATA)) begin
         dl0_d = rx_byte;
         dl1_d = dl0_q;
         if (held_q == 2'd2) begin
            data_out_d   = dl1_q;
            data_valid_d = 1'b1;
         end else begin
            held_d = held_q + 2'd1;
         end
      end
      if (!rx_abort && rx_eop && (state_d == ST_IDLE)) held_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dl0_q        <= '0;
         dl1_q        <= '0;
         held_q       <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
      end else begin
         dl0_q        <= dl0_d;
         dl1_q        <= dl1_d;
         held_q       <= held_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign rx_data_out   = data_out_q;
   assign rx_data_valid = data_valid_q;
`else
   assign rx_data_out   = '0;
   assign rx_data_valid = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_pkt_parser.sv
// tb_usb_rx_pkt_parser
//   Directed and randomized packets for usb_rx_pkt_parser, checked against a
//   packet-level reference model (PID classification, byte counts, CRC
//   residuals over the received bit stream, payload extraction).
module tb_usb_rx_pkt_parser;
   localparam int unsigned MAXP = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  self_addr;
   logic [7:0]  rx_byte;
   logic        rx_byte_valid, rx_sop, rx_eop, rx_abort;
   logic        rx_pkt_valid, crc5_err, crc16_err, pid_err, len_err, addr_match, rx_data_valid;
   logic [3:0]  rx_pid_val, rx_endp;
   logic [10:0] rx_payload_len;
   logic [7:0]  rx_data_out;

   int n_tests = 0;
   int n_fail  = 0;
   int pulse_cnt = 0;
   logic [7:0] got_data[$];
   logic [7:0] exp_data[$];

   typedef struct packed {
      logic [3:0]  pid;
      logic        crc5;
      logic        crc16;
      logic        pid_err;
      logic        len;
      logic        am;
      logic [3:0]  endp;
      logic [10:0] plen;
      logic        chk_crc16;
      logic        chk_am;
      logic        chk_endp;
      logic        chk_plen;
   } exp_t;
   exp_t last_e;

   usb_rx_pkt_parser #(.MAX_PAYLOAD(MAXP)) dut (
      .clk(clk), .rst(rst), .self_addr(self_addr), .rx_byte(rx_byte),
      .rx_byte_valid(rx_byte_valid), .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_abort(rx_abort),
      .rx_pkt_valid(rx_pkt_valid), .rx_pid_val(rx_pid_val), .crc5_err(crc5_err),
      .crc16_err(crc16_err), .pid_err(pid_err), .len_err(len_err), .addr_match(addr_match),
      .rx_endp(rx_endp), .rx_payload_len(rx_payload_len), .rx_data_out(rx_data_out),
      .rx_data_valid(rx_data_valid)
   );

   always #5 clk = ~clk;

   // Record packet pulses and forwarded payload just after each edge
   always begin
      @(posedge clk);
      #1;
      if (rx_pkt_valid) pulse_cnt++;
      if (rx_data_valid) got_data.push_back(rx_data_out);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Generic serial CRC over a bit list; w is the register width
   function automatic logic [15:0] lfsr(input bit bits[$], input int w,
                                        input logic [15:0] poly, input logic [15:0] init);
      logic [15:0] c;
      logic [15:0] mask;
      logic        fb;
      mask = 16'((32'd1 << w) - 32'd1);
      c = init;
      foreach (bits[i]) begin
         fb = c[4'(w - 1)] ^ bits[i];
         c = (c << 1) & mask;
         if (fb) c = c ^ poly;
      end
      return c;
   endfunction

   task automatic gen_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] endp,
                            output logic [7:0] p[$]);
      bit bits[$];
      logic [10:0] fld;
      logic [15:0] r;
      logic [4:0]  f;
      fld = {endp, addr};
      for (int i = 0; i < 11; i++) bits.push_back(fld[i]);
      r = lfsr(bits, 5, 16'h0005, 16'h001F);
      for (int i = 0; i < 5; i++) f[i] = ~r[4 - i];
      p.delete();
      p.push_back({~pid, pid});
      p.push_back({endp[0], addr});
      p.push_back({f, endp[3:1]});
   endtask

   task automatic gen_data(input logic [3:0] pid, input logic [7:0] pl[$], output logic [7:0] p[$]);
      bit bits[$];
      logic [15:0] r;
      logic [15:0] c;
      foreach (pl[i]) for (int j = 0; j < 8; j++) bits.push_back(pl[i][j]);
      r = lfsr(bits, 16, 16'h8005, 16'hFFFF);
      for (int k = 0; k < 16; k++) c[k] = ~r[15 - k];
      p.delete();
      p.push_back({~pid, pid});
      foreach (pl[i]) p.push_back(pl[i]);
      p.push_back(c[7:0]);
      p.push_back(c[15:8]);
   endtask

   // Reference model: expected status and forwarded payload of one packet
   task automatic model_pkt(input logic [7:0] p[$], input logic [6:0] sa, output exp_t e);
      bit bits[$];
      int n;
      int kind;
      logic [3:0]  pid;
      logic [15:0] r;
      e = '0;
      e.chk_crc16 = 1'b1;
      e.chk_am = 1'b1;
      exp_data.delete();
      n = p.size() - 1;
      pid = p[0][3:0];
      e.pid = pid;
      if (p[0][7:4] != ~pid) kind = 3;
      else begin
         case (pid)
            4'h1, 4'h9, 4'h5, 4'hD: kind = 0;
            4'h3, 4'hB:             kind = 1;
            4'h2, 4'hA, 4'hE:       kind = 2;
            default:                kind = 3;
         endcase
      end
      case (kind)
         0: begin
            e.len = (n != 2);
            if (n == 2) begin
               for (int i = 1; i <= 2; i++) for (int j = 0; j < 8; j++) bits.push_back(p[i][j]);
               r = lfsr(bits, 5, 16'h0005, 16'h001F);
               e.crc5 = (r[4:0] != 5'b01100);
               e.endp = {p[2][2:0], p[1][7]};
               e.chk_endp = 1'b1;
               e.am = (pid != 4'h5) && (p[1][6:0] == sa);
            end else e.chk_am = 1'b0;
         end
         1: begin
            e.len = (n < 2) || ((n - 2) > int'(MAXP));
            if (n >= 2) begin
               for (int i = 1; i <= n; i++) for (int j = 0; j < 8; j++) bits.push_back(p[i][j]);
               r = lfsr(bits, 16, 16'h8005, 16'hFFFF);
               e.crc16 = (r != 16'h800D);
               e.plen = 11'(n - 2);
               e.chk_plen = 1'b1;
`ifdef USB_RX_PAYLOAD_EN
               for (int i = 1; i <= n - 2; i++) exp_data.push_back(p[i]);
`endif
            end else e.chk_crc16 = 1'b0;
         end
         2: e.len = (n != 0);
         default: e.pid_err = 1'b1;
      endcase
   endtask

   task automatic drive(input logic v, input logic s, input logic [7:0] b, input logic eop);
      @(negedge clk);
      rx_byte_valid = v;
      rx_sop = s;
      rx_byte = b;
      rx_eop = eop;
      rx_abort = 1'b0;
   endtask

   task automatic check_pkt(input exp_t e, input int bp, input int bd);
      chk("pkt_valid", 32'(rx_pkt_valid), 32'd1);
      chk("pulse_count", 32'(pulse_cnt - bp), 32'd1);
      chk("pid_val", 32'(rx_pid_val), 32'(e.pid));
      chk("pid_err", 32'(pid_err), 32'(e.pid_err));
      chk("len_err", 32'(len_err), 32'(e.len));
      chk("crc5_err", 32'(crc5_err), 32'(e.crc5));
      if (e.chk_crc16) chk("crc16_err", 32'(crc16_err), 32'(e.crc16));
      if (e.chk_am)    chk("addr_match", 32'(addr_match), 32'(e.am));
      if (e.chk_endp)  chk("endp", 32'(rx_endp), 32'(e.endp));
      if (e.chk_plen)  chk("payload_len", 32'(rx_payload_len), 32'(e.plen));
      chk("data_count", 32'(got_data.size() - bd), 32'(exp_data.size()));
      for (int i = 0; i < exp_data.size() && (bd + i) < got_data.size(); i++)
         chk("data_byte", 32'(got_data[bd + i]), 32'(exp_data[i]));
      last_e = e;
   endtask

   task automatic run_pkt(input logic [7:0] p[$], input bit eop_last, input int max_gap);
      exp_t e;
      int bp, bd;
      model_pkt(p, self_addr, e);
      bp = pulse_cnt;
      bd = got_data.size();
      for (int i = 0; i < p.size(); i++) begin
         if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) drive(1'b0, 1'b0, 8'h00, 1'b0);
         drive(1'b1, i == 0, p[i], eop_last && (i == p.size() - 1));
      end
      if (!eop_last) drive(1'b0, 1'b0, 8'h00, 1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      check_pkt(e, bp, bd);
   endtask

   initial begin
      logic [7:0] p[$];
      logic [7:0] pl[$];
      logic [7:0] tmp;
      logic [3:0] pid;
      int bp, bi, n;

      rst = 1'b1;
      self_addr = '0;
      rx_byte = '0;
      rx_byte_valid = 1'b0;
      rx_sop = 1'b0;
      rx_eop = 1'b0;
      rx_abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pkt_valid", 32'(rx_pkt_valid), 32'd0);
      chk("rst_status", 32'({rx_pid_val, crc5_err, crc16_err, pid_err, len_err, addr_match, rx_endp}), 32'd0);
      chk("rst_payload_len", 32'(rx_payload_len), 32'd0);
      chk("rst_data", 32'({rx_data_out, rx_data_valid}), 32'd0);
      rst = 1'b0;

      // SETUP addr 0 endp 0 with good CRC5
      p = '{8'h2D, 8'h00, 8'h10};
      run_pkt(p, 1'b0, 0);
      chk("setup_pid", 32'(rx_pid_val), 32'hD);
      chk("setup_addr_match", 32'(addr_match), 32'd1);
      chk("setup_errs", 32'({crc5_err, crc16_err, pid_err, len_err}), 32'd0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      chk("pulse_one_cycle", 32'(rx_pkt_valid), 32'd0);
      chk("status_hold", 32'({rx_pid_val, addr_match}), 32'h1B);

      p = '{8'h2D, 8'h00, 8'h18};
      run_pkt(p, 1'b0, 0);
      chk("crc5_bad", 32'(crc5_err), 32'd1);

      p = '{8'hC3, 8'h00, 8'h00};
      run_pkt(p, 1'b1, 0);
      chk("empty_len", 32'(rx_payload_len), 32'd0);
      chk("empty_crc", 32'(crc16_err), 32'd0);

      pl = '{8'h00, 8'h01, 8'h02, 8'h03};
      gen_data(4'hB, pl, p);
      run_pkt(p, 1'b0, 0);
      chk("data4_len", 32'(rx_payload_len), 32'd4);
      chk("data4_crc", 32'(crc16_err), 32'd0);

      tmp = p[2];
      tmp[2] = ~tmp[2];
      p[2] = tmp;
      run_pkt(p, 1'b1, 1);
      chk("data4_flip_crc", 32'(crc16_err), 32'd1);

      p = '{8'hD2, 8'h55};
      run_pkt(p, 1'b0, 0);
      chk("ack_extra_len", 32'(len_err), 32'd1);

      p = '{8'h2E};
      run_pkt(p, 1'b0, 0);
      chk("bad_pid", 32'(pid_err), 32'd1);

      // Abort in the middle of a data packet
      bp = pulse_cnt;
      drive(1'b1, 1'b1, 8'hC3, 1'b0);
      drive(1'b1, 1'b0, 8'h11, 1'b0);
      drive(1'b1, 1'b0, 8'h22, 1'b0);
      drive(1'b1, 1'b0, 8'h33, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      rx_abort = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
      chk("abort_no_pulse", 32'(pulse_cnt - bp), 32'd0);
      chk("abort_hold", 32'({rx_pid_val, pid_err}), 32'({last_e.pid, last_e.pid_err}));
      chk("abort_data_idle", 32'(rx_data_valid), 32'd0);
      p = '{8'h2D, 8'h00, 8'h10};
      run_pkt(p, 1'b0, 0);

      // New SOP mid-packet discards the old packet
      bp = pulse_cnt;
      drive(1'b1, 1'b1, 8'h4B, 1'b0);
      drive(1'b1, 1'b0, 8'h11, 1'b0);
      drive(1'b1, 1'b0, 8'h22, 1'b0);
      run_pkt(p, 1'b1, 0);
      chk("sop_restart_pulses", 32'(pulse_cnt - bp), 32'd1);

      // EOP in idle is ignored
      bp = pulse_cnt;
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
      chk("idle_eop", 32'(pulse_cnt - bp), 32'd0);

      // Reset mid-packet
      bp = pulse_cnt;
      drive(1'b1, 1'b1, 8'h2D, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b0);
      chk("reset_mid_pulse", 32'(pulse_cnt - bp), 32'd0);
      chk("reset_mid_pid", 32'(rx_pid_val), 32'd0);

      for (int t = 0; t < 150; t++) begin
         self_addr = 7'($urandom);
         p.delete();
         case ($urandom_range(3, 0))
            0: begin
               case ($urandom_range(3, 0))
                  0: pid = 4'h1;
                  1: pid = 4'h9;
                  2: pid = 4'h5;
                  default: pid = 4'hD;
               endcase
               gen_token(pid, ($urandom_range(1, 0) == 1) ? self_addr : 7'($urandom), 4'($urandom), p);
               if ($urandom_range(3, 0) == 0) begin
                  bi = $urandom_range(15, 0);
                  tmp = p[1 + bi / 8];
                  tmp[bi % 8] = ~tmp[bi % 8];
                  p[1 + bi / 8] = tmp;
               end
               if ($urandom_range(7, 0) == 0) void'(p.pop_back());
               else if ($urandom_range(7, 0) == 0) p.push_back(8'($urandom));
            end
            1: begin
               pl.delete();
               n = $urandom_range(MAXP + 2, 0);
               repeat (n) pl.push_back(8'($urandom));
               gen_data(($urandom_range(1, 0) == 1) ? 4'hB : 4'h3, pl, p);
               if ($urandom_range(3, 0) == 0) begin
                  bi = $urandom_range((n + 2) * 8 - 1, 0);
                  tmp = p[1 + bi / 8];
                  tmp[bi % 8] = ~tmp[bi % 8];
                  p[1 + bi / 8] = tmp;
               end
               if ($urandom_range(15, 0) == 0) begin
                  p.delete();
                  p.push_back(8'hC3);
                  if ($urandom_range(1, 0) == 1) p.push_back(8'($urandom));
               end
            end
            2: begin
               case ($urandom_range(2, 0))
                  0: pid = 4'h2;
                  1: pid = 4'hA;
                  default: pid = 4'hE;
               endcase
               p.push_back({~pid, pid});
               if ($urandom_range(3, 0) == 0) p.push_back(8'($urandom));
            end
            default: begin
               p.push_back(8'($urandom));
               repeat ($urandom_range(3, 0)) p.push_back(8'($urandom));
            end
         endcase
         run_pkt(p, $urandom_range(1, 0) == 1, $urandom_range(2, 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
